// File: rtl/toy_bus_pkg.sv
// ---------------------------------------------------------------------------
// toy_bus_pkg
//   Shared types for the toy bus DTCM scheduler.
//   - toy_bus_req_t / toy_bus_ack_t : packed request/ack payloads
//   - REQ_W / ACK_W                 : payload widths (361 / 297)
//   - OS_CNT_W                      : outstanding-counter width
//   - sched_state_e                 : scheduler FSM states
// ---------------------------------------------------------------------------
package toy_bus_pkg;

  localparam int unsigned REQ_W    = 361;
  localparam int unsigned ACK_W    = 297;
  localparam int unsigned OS_CNT_W = 4;

  typedef struct packed {
    logic [31:0]  addr;
    logic [31:0]  strb;
    logic [255:0] data;
    logic         opcode;
    logic [3:0]   src_id;
    logic [3:0]   tgt_id;
    logic [31:0]  sideband;
  } toy_bus_req_t;

  typedef struct packed {
    logic         opcode;
    logic [255:0] data;
    logic [31:0]  sideband;
    logic [3:0]   src_id;
    logic [3:0]   tgt_id;
  } toy_bus_ack_t;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } sched_state_e;

endpackage

// File: rtl/toy_bus_os_cnt.sv
// ---------------------------------------------------------------------------
// toy_bus_os_cnt
//   Saturating up/down credit counter tracking outstanding requests of one
//   initiator.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     inc_i         : request handshake this cycle
//     dec_i         : ack handshake this cycle
//     cnt_o         : current outstanding count
//     full_o        : cnt_o has reached MAX
//     underflow_o   : decrement requested while count is 0 (count holds at 0)
// ---------------------------------------------------------------------------
module toy_bus_os_cnt
  import toy_bus_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [OS_CNT_W-1:0] cnt_o,
  output logic                full_o,
  output logic                underflow_o
);

  logic [OS_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + OS_CNT_W'(1);
        end
      end
      2'b01: begin
        if (cnt_q == '0) begin
          underflow_o = 1'b1;
        end else begin
          cnt_d = cnt_q - OS_CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q >= OS_CNT_W'(MAX));

endmodule

// File: rtl/toy_bus_dtcm_sched.sv
// ---------------------------------------------------------------------------
// toy_bus_dtcm_sched
//   Two-requester scheduler for the DTCM port: round-robin arbitration with a
//   grant lock under backpressure, per-initiator outstanding credit limits,
//   and ack routing by tgt_id. Data paths are purely combinational.
//   Ports:
//     clk, rst                           : clock, sync active-high reset
//     inN_req_vld/rdy/pld  (N=0,1)       : initiator request channels
//     out0_req_vld/rdy/pld               : DTCM request channel
//     out0_ack_vld/rdy/pld               : DTCM ack channel
//     inN_ack_vld/rdy/pld  (N=0,1)       : acks routed back to initiators
//     os0_cnt, os1_cnt                   : outstanding counts
//     bad_ack                            : sticky unmatched-ack/underflow flag
//   Optional (TOY_BUS_DTCM_SCHED_STAT_EN):
//     gnt0_cnt, gnt1_cnt, stall_cnt      : 32-bit wrapping statistics
// ---------------------------------------------------------------------------
module toy_bus_dtcm_sched
  import toy_bus_pkg::*;
#(
  parameter int unsigned MAX_OS = 4,
  parameter logic [3:0]  IN0_ID = 4'd0,
  parameter logic [3:0]  IN1_ID = 4'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in0_req_vld,
  output logic                in0_req_rdy,
  input  logic [REQ_W-1:0]    in0_req_pld,
  input  logic                in1_req_vld,
  output logic                in1_req_rdy,
  input  logic [REQ_W-1:0]    in1_req_pld,
  output logic                out0_req_vld,
  input  logic                out0_req_rdy,
  output logic [REQ_W-1:0]    out0_req_pld,
  input  logic                out0_ack_vld,
  output logic                out0_ack_rdy,
  input  logic [ACK_W-1:0]    out0_ack_pld,
  output logic                in0_ack_vld,
  input  logic                in0_ack_rdy,
  output logic [ACK_W-1:0]    in0_ack_pld,
  output logic                in1_ack_vld,
  input  logic                in1_ack_rdy,
  output logic [ACK_W-1:0]    in1_ack_pld,
  output logic [OS_CNT_W-1:0] os0_cnt,
  output logic [OS_CNT_W-1:0] os1_cnt,
  output logic                bad_ack
`ifdef TOY_BUS_DTCM_SCHED_STAT_EN
  ,
  output logic [31:0]         gnt0_cnt,
  output logic [31:0]         gnt1_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  sched_state_e state_q, state_d;
  logic         gnt_q, gnt_d;
  logic         prio_q, prio_d;
  logic         bad_ack_q, bad_ack_d;

  logic         full0, full1;
  logic         uf0, uf1;
  logic         elig0, elig1;
  logic         sel;
  logic         req_vld;
  logic         req_hs;
  logic         inc0, inc1, dec0, dec1;
  logic         hit0, hit1;
  toy_bus_ack_t ack;

  assign elig0 = in0_req_vld && !full0;
  assign elig1 = in1_req_vld && !full1;

  // req_vld depends only on state and initiator inputs, never on
  // out0_req_rdy, so the DTCM side sees no rdy->vld loop.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel     = 1'b0;
    req_vld = 1'b0;
    case (state_q)
      ARB: begin
        req_vld = elig0 || elig1;
        sel     = (elig0 && elig1) ? prio_q : elig1;
        if (req_vld && !out0_req_rdy) begin
          state_d = LOCK;
          gnt_d   = sel;
        end
      end
      LOCK: begin
        sel     = gnt_q;
        req_vld = gnt_q ? in1_req_vld : in0_req_vld;
        if (req_vld && out0_req_rdy) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign out0_req_vld = req_vld;
  assign out0_req_pld = sel ? in1_req_pld : in0_req_pld;
  assign in0_req_rdy  = req_vld && !sel && out0_req_rdy;
  assign in1_req_rdy  = req_vld &&  sel && out0_req_rdy;
  assign req_hs       = req_vld && out0_req_rdy;
  assign prio_d       = req_hs ? ~sel : prio_q;

  assign inc0 = req_hs && !sel;
  assign inc1 = req_hs &&  sel;

  // Ack routing by target ID; unmatched acks are sunk and flagged.
  assign ack          = toy_bus_ack_t'(out0_ack_pld);
  assign hit0         = (ack.tgt_id == IN0_ID);
  assign hit1         = (ack.tgt_id == IN1_ID);
  assign in0_ack_vld  = out0_ack_vld && hit0;
  assign in1_ack_vld  = out0_ack_vld && hit1;
  assign in0_ack_pld  = out0_ack_pld;
  assign in1_ack_pld  = out0_ack_pld;
  assign out0_ack_rdy = hit0 ? in0_ack_rdy : (hit1 ? in1_ack_rdy : 1'b1);
  assign dec0         = in0_ack_vld && in0_ack_rdy;
  assign dec1         = in1_ack_vld && in1_ack_rdy;

  assign bad_ack_d = bad_ack_q || uf0 || uf1 ||
                     (out0_ack_vld && !hit0 && !hit1);

  toy_bus_os_cnt #(.MAX(MAX_OS)) u_os0 (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (inc0),
    .dec_i       (dec0),
    .cnt_o       (os0_cnt),
    .full_o      (full0),
    .underflow_o (uf0)
  );

  toy_bus_os_cnt #(.MAX(MAX_OS)) u_os1 (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (inc1),
    .dec_i       (dec1),
    .cnt_o       (os1_cnt),
    .full_o      (full1),
    .underflow_o (uf1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      gnt_q     <= 1'b0;
      prio_q    <= 1'b0;
      bad_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      prio_q    <= prio_d;
      bad_ack_q <= bad_ack_d;
    end
  end

  assign bad_ack = bad_ack_q;

`ifdef TOY_BUS_DTCM_SCHED_STAT_EN
  logic [31:0] gnt0_q, gnt1_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_q  <= '0;
      gnt1_q  <= '0;
      stall_q <= '0;
    end else begin
      if (inc0) begin
        gnt0_q <= gnt0_q + 32'd1;
      end
      if (inc1) begin
        gnt1_q <= gnt1_q + 32'd1;
      end
      if (req_vld && !out0_req_rdy) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign gnt0_cnt  = gnt0_q;
  assign gnt1_cnt  = gnt1_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_toy_bus_dtcm_sched.sv
// ---------------------------------------------------------------------------
// tb_toy_bus_dtcm_sched
//   Directed, table-driven bench for toy_bus_dtcm_sched (MAX_OS = 4,
//   IN0_ID = 0, IN1_ID = 1), followed by hand-written sequences for acks,
//   credit boundaries, underflow and reset during a lock.
// ---------------------------------------------------------------------------
module tb_toy_bus_dtcm_sched;
  import toy_bus_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in0_req_vld, in1_req_vld, out0_req_rdy;
  logic         in0_req_rdy, in1_req_rdy, out0_req_vld;
  toy_bus_req_t in0_req_pld, in1_req_pld, out0_req_pld;
  logic         out0_ack_vld, out0_ack_rdy;
  logic         in0_ack_vld, in0_ack_rdy, in1_ack_vld, in1_ack_rdy;
  toy_bus_ack_t out0_ack_pld, in0_ack_pld, in1_ack_pld;
  logic [3:0]   os0_cnt, os1_cnt;
  logic         bad_ack;
`ifdef TOY_BUS_DTCM_SCHED_STAT_EN
  logic [31:0]  gnt0_cnt, gnt1_cnt, stall_cnt;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  toy_bus_dtcm_sched #(.MAX_OS(4), .IN0_ID(4'd0), .IN1_ID(4'd1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in0_req_vld  (in0_req_vld),
    .in0_req_rdy  (in0_req_rdy),
    .in0_req_pld  (in0_req_pld),
    .in1_req_vld  (in1_req_vld),
    .in1_req_rdy  (in1_req_rdy),
    .in1_req_pld  (in1_req_pld),
    .out0_req_vld (out0_req_vld),
    .out0_req_rdy (out0_req_rdy),
    .out0_req_pld (out0_req_pld),
    .out0_ack_vld (out0_ack_vld),
    .out0_ack_rdy (out0_ack_rdy),
    .out0_ack_pld (out0_ack_pld),
    .in0_ack_vld  (in0_ack_vld),
    .in0_ack_rdy  (in0_ack_rdy),
    .in0_ack_pld  (in0_ack_pld),
    .in1_ack_vld  (in1_ack_vld),
    .in1_ack_rdy  (in1_ack_rdy),
    .in1_ack_pld  (in1_ack_pld),
    .os0_cnt      (os0_cnt),
    .os1_cnt      (os1_cnt),
    .bad_ack      (bad_ack)
`ifdef TOY_BUS_DTCM_SCHED_STAT_EN
    ,
    .gnt0_cnt     (gnt0_cnt),
    .gnt1_cnt     (gnt1_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  typedef struct {
    logic       v0, v1, rdy;
    logic       e_vld, e_sel, e_r0, e_r1;
    logic [3:0] e_os0, e_os1;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one cycle; inputs are driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ack(input logic vld, input logic [3:0] tgt);
    out0_ack_vld        = vld;
    out0_ack_pld        = '0;
    out0_ack_pld.tgt_id = tgt;
    out0_ack_pld.data   = 256'h55AA;
  endtask

  initial begin
    //             v0 v1 rdy vld sel r0 r1 os0 os1
    tbl[0]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 4'd0,4'd0};
    tbl[1]  = '{1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, 4'd0,4'd0};
    tbl[2]  = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 4'd1,4'd0};
    tbl[3]  = '{1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, 4'd1,4'd1};
    tbl[4]  = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 4'd2,4'd1};
    tbl[5]  = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 4'd2,4'd2};
    tbl[6]  = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 4'd2,4'd2};
    tbl[7]  = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 4'd2,4'd2};
    tbl[8]  = '{1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, 4'd2,4'd2};
    tbl[9]  = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 4'd3,4'd2};
    tbl[10] = '{1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0, 4'd3,4'd3};
    tbl[11] = '{1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 4'd4,4'd3};
    tbl[12] = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 4'd4,4'd3};
    tbl[13] = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 4'd4,4'd4};

    in0_req_pld      = '0;
    in0_req_pld.addr = 32'hA0;
    in1_req_pld      = '0;
    in1_req_pld.addr = 32'hB1;
    in0_req_vld = 1'b0; in1_req_vld = 1'b0; out0_req_rdy = 1'b0;
    in0_ack_rdy = 1'b0; in1_ack_rdy = 1'b0;
    set_ack(1'b0, 4'd0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_bad_ack", {31'd0, bad_ack}, 32'd0);
    chk("reset_out_vld", {31'd0, out0_req_vld}, 32'd0);
    chk("reset_ack_vld", {30'd0, in0_ack_vld, in1_ack_vld}, 32'd0);

    // Contention, backpressure lock and credit fill
    for (int i = 0; i < 14; i++) begin
      in0_req_vld  = tbl[i].v0;
      in1_req_vld  = tbl[i].v1;
      out0_req_rdy = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_vld", i), {31'd0, out0_req_vld}, {31'd0, tbl[i].e_vld});
      chk($sformatf("v%0d_r0", i),  {31'd0, in0_req_rdy},  {31'd0, tbl[i].e_r0});
      chk($sformatf("v%0d_r1", i),  {31'd0, in1_req_rdy},  {31'd0, tbl[i].e_r1});
      chk($sformatf("v%0d_os0", i), {28'd0, os0_cnt},      {28'd0, tbl[i].e_os0});
      chk($sformatf("v%0d_os1", i), {28'd0, os1_cnt},      {28'd0, tbl[i].e_os1});
      if (tbl[i].e_vld)
        chk($sformatf("v%0d_pld", i), out0_req_pld.addr,
            tbl[i].e_sel ? 32'hB1 : 32'hA0);
      tick();
    end

    // Ack to in0 while full: the request stays blocked this cycle,
    // the returned credit re-enables in0 on the next cycle.
    in1_req_vld = 1'b0;
    in0_req_vld = 1'b1;
    out0_req_rdy = 1'b1;
    in0_ack_rdy = 1'b1;
    set_ack(1'b1, 4'd0);
    #1;
    chk("ack0_vld", {30'd0, in0_ack_vld, in1_ack_vld}, 32'd2);
    chk("ack0_rdy", {31'd0, out0_ack_rdy}, 32'd1);
    chk("ack0_pld", in0_ack_pld.data[31:0], 32'h55AA);
    chk("full_r0", {31'd0, in0_req_rdy}, 32'd0);
    tick();
    set_ack(1'b0, 4'd0);
    #1;
    chk("ack0_os0", {28'd0, os0_cnt}, 32'd3);
    chk("reen_r0", {31'd0, in0_req_rdy}, 32'd1);
    tick();
    in0_req_vld = 1'b0;
    #1;
    chk("refill_os0", {28'd0, os0_cnt}, 32'd4);

    // Drain in1 to 2, then simultaneous inc/dec on in1
    in1_ack_rdy = 1'b1;
    set_ack(1'b1, 4'd1);
    tick(); tick();
    #1;
    chk("drain_os1", {28'd0, os1_cnt}, 32'd2);
    in1_req_vld = 1'b1;
    #1;
    chk("incdec_r1", {31'd0, in1_req_rdy}, 32'd1);
    chk("incdec_ackv", {31'd0, in1_ack_vld}, 32'd1);
    tick();
    in1_req_vld = 1'b0;
    set_ack(1'b0, 4'd0);
    #1;
    chk("incdec_os1", {28'd0, os1_cnt}, 32'd2);

    // Ack routing: blocked in1, then an unmatched target
    in1_ack_rdy = 1'b0;
    set_ack(1'b1, 4'd1);
    #1;
    chk("ack1_blk_rdy", {31'd0, out0_ack_rdy}, 32'd0);
    chk("ack1_blk_vld", {31'd0, in1_ack_vld}, 32'd1);
    chk("pre_bad_ack", {31'd0, bad_ack}, 32'd0);
    tick();
    set_ack(1'b1, 4'd7);
    #1;
    chk("ack1_blk_os1", {28'd0, os1_cnt}, 32'd2);
    chk("ack7_rdy", {31'd0, out0_ack_rdy}, 32'd1);
    chk("ack7_vld", {30'd0, in0_ack_vld, in1_ack_vld}, 32'd0);
    tick();
    set_ack(1'b0, 4'd0);
    #1;
    chk("bad_ack_set", {31'd0, bad_ack}, 32'd1);
    tick();
    #1;
    chk("bad_ack_sticky", {31'd0, bad_ack}, 32'd1);

    // Reset while locked on in0 with os0 = 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in0_req_vld = 1'b1;
    out0_req_rdy = 1'b1;
    tick(); tick(); tick();
    out0_req_rdy = 1'b0;
    #1;
    chk("pre_lock_os0", {28'd0, os0_cnt}, 32'd3);
    tick();
    in1_req_vld = 1'b1;
    #1;
    chk("lock_pld", out0_req_pld.addr, 32'hA0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in0_req_vld = 1'b0;
    #1;
    chk("rst_os0", {28'd0, os0_cnt}, 32'd0);
    chk("rst_bad_ack", {31'd0, bad_ack}, 32'd0);
    chk("rst_unlock_vld", {31'd0, out0_req_vld}, 32'd1);
    chk("rst_unlock_pld", out0_req_pld.addr, 32'hB1);
`ifdef TOY_BUS_DTCM_SCHED_STAT_EN
    chk("rst_stats", gnt0_cnt | gnt1_cnt | stall_cnt, 32'd0);
`endif
    in0_req_vld = 1'b1;
    out0_req_rdy = 1'b1;
    #1;
    chk("rst_prio_r0", {31'd0, in0_req_rdy}, 32'd1);
    tick();
    in0_req_vld = 1'b0;
    in1_req_vld = 1'b0;

    // Underflow: ack for in1 with nothing outstanding
    in1_ack_rdy = 1'b1;
    set_ack(1'b1, 4'd1);
    tick();
    set_ack(1'b0, 4'd0);
    #1;
    chk("uf_os1", {28'd0, os1_cnt}, 32'd0);
    chk("uf_bad_ack", {31'd0, bad_ack}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
